// File: rtl/int_mem_sram_arb.sv
// Single-port SRAM arbiter for the internal-memory subsystem.
// Three masters share one synchronous SRAM: the boot-loader write stream
// (absolute priority, never stalled), the CPU instruction bus (read-only)
// and the CPU data bus (read/write). The two CPU buses get registered
// one-cycle ready pulses; read data comes straight from the SRAM.
//
// grant     | meaning
// GNT_NONE  | no eligible request, SRAM idle
// GNT_BOOT  | boot-loader write drives the SRAM
// GNT_I     | instruction read drives the SRAM
// GNT_D     | data read/write drives the SRAM
module int_mem_sram_arb #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int SRAM_ADDR_W = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     boot_valid,
  input  logic [ADDR_W-1:0]        boot_addr,
  input  logic [DATA_W-1:0]        boot_wdata,
  input  logic [DATA_W/8-1:0]      boot_wstrb,
  input  logic                     i_valid,
  input  logic [ADDR_W-1:0]        i_addr,
  output logic [DATA_W-1:0]        i_rdata,
  output logic                     i_ready,
  input  logic                     d_valid,
  input  logic [ADDR_W-1:0]        d_addr,
  input  logic [DATA_W-1:0]        d_wdata,
  input  logic [DATA_W/8-1:0]      d_wstrb,
  output logic [DATA_W-1:0]        d_rdata,
  output logic                     d_ready,
  output logic                     sram_en,
  output logic [DATA_W/8-1:0]      sram_we,
  output logic [SRAM_ADDR_W-3:0]   sram_addr,
  output logic [DATA_W-1:0]        sram_wdata,
  input  logic [DATA_W-1:0]        sram_rdata
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_BOOT = 2'd1,
    GNT_I    = 2'd2,
    GNT_D    = 2'd3
  } gnt_e;

  gnt_e gnt;
  logic i_elig;
  logic d_elig;
  logic i_ready_q, i_ready_d;
  logic d_ready_q, d_ready_d;
  // 0 = instruction bus won the last CPU grant, 1 = data bus
  logic last_grant_q, last_grant_d;

  // Grant select: boot first, then the single eligible CPU master, ties by round-robin.
  // A master in its ready cycle is excluded so a held valid is not served twice.
  always_comb begin
    gnt    = GNT_NONE;
    i_elig = i_valid & ~i_ready_q;
    d_elig = d_valid & ~d_ready_q;
    if (boot_valid) begin
      gnt = GNT_BOOT;
    end else if (i_elig && d_elig) begin
      gnt = last_grant_q ? GNT_I : GNT_D;
    end else if (i_elig) begin
      gnt = GNT_I;
    end else if (d_elig) begin
      gnt = GNT_D;
    end
  end

  // SRAM drive for the granted master; enables are held off while in reset.
  always_comb begin
    sram_en    = 1'b0;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    unique case (gnt)
      GNT_BOOT: begin
        sram_en    = 1'b1;
        sram_we    = boot_wstrb;
        sram_addr  = boot_addr[SRAM_ADDR_W-1:2];
        sram_wdata = boot_wdata;
      end
      GNT_I: begin
        sram_en    = 1'b1;
        sram_addr  = i_addr[SRAM_ADDR_W-1:2];
      end
      GNT_D: begin
        sram_en    = 1'b1;
        sram_we    = d_wstrb;
        sram_addr  = d_addr[SRAM_ADDR_W-1:2];
        sram_wdata = d_wdata;
      end
      default: begin
        sram_en    = 1'b0;
      end
    endcase
    if (rst) begin
      sram_en = 1'b0;
      sram_we = {STRB_W{1'b0}};
    end
  end

  // Next-state: ready follows a CPU grant by one cycle; boot grants do not touch last_grant.
  always_comb begin
    i_ready_d    = (gnt == GNT_I);
    d_ready_d    = (gnt == GNT_D);
    last_grant_d = last_grant_q;
    if (gnt == GNT_I) begin
      last_grant_d = 1'b0;
    end else if (gnt == GNT_D) begin
      last_grant_d = 1'b1;
    end
  end

  // Response and round-robin registers; reset drops any pending ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign i_ready = i_ready_q;
  assign d_ready = d_ready_q;
  assign i_rdata = sram_rdata;
  assign d_rdata = sram_rdata;

  // Upper address bits alias by truncation and byte-offset bits are irrelevant to a word SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{boot_addr[ADDR_W-1:SRAM_ADDR_W], boot_addr[1:0],
                              i_addr[ADDR_W-1:SRAM_ADDR_W], i_addr[1:0],
                              d_addr[ADDR_W-1:SRAM_ADDR_W], d_addr[1:0]};

endmodule

// File: tb/tb_int_mem_sram_arb.sv
// Bench for int_mem_sram_arb: directed cycle table, reset-mid-transfer
// sequence, then random traffic checked against a transaction-level model.
module tb_int_mem_sram_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot_valid;
  logic [31:0] boot_addr, boot_wdata;
  logic [3:0]  boot_wstrb;
  logic        i_valid;
  logic [31:0] i_addr, i_rdata;
  logic        i_ready;
  logic        d_valid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        d_ready;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [10:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  int_mem_sram_arb #(.DATA_W(32), .ADDR_W(32), .SRAM_ADDR_W(13)) dut (
    .clk(clk), .rst(rst),
    .boot_valid(boot_valid), .boot_addr(boot_addr), .boot_wdata(boot_wdata), .boot_wstrb(boot_wstrb),
    .i_valid(i_valid), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: read data one cycle after enable, byte writes; side port for preload
  logic [31:0] mem [0:2047];
  logic        pl_we = 1'b0;
  logic [10:0] pl_addr;
  logic [31:0] pl_data;
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (sram_en) begin
      sram_rdata <= mem[sram_addr];
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        bv; logic [31:0] ba; logic [31:0] bd; logic [3:0] bs;
    logic        iv; logic [31:0] ia;
    logic        dv; logic [31:0] da; logic [31:0] dd; logic [3:0] ds;
    logic        e_en; logic [3:0] e_we; logic [10:0] e_addr; logic [31:0] e_wd;
    logic        e_ir; logic e_dr; logic ck_rd; logic [31:0] e_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(
    input logic bv, input logic [31:0] ba, input logic [31:0] bd, input logic [3:0] bs,
    input logic iv, input logic [31:0] ia,
    input logic dv, input logic [31:0] da, input logic [31:0] dd, input logic [3:0] ds,
    input logic e_en, input logic [3:0] e_we, input logic [10:0] e_addr, input logic [31:0] e_wd,
    input logic e_ir, input logic e_dr, input logic ck_rd, input logic [31:0] e_rd);
    vec_t v;
    v.bv = bv; v.ba = ba; v.bd = bd; v.bs = bs; v.iv = iv; v.ia = ia;
    v.dv = dv; v.da = da; v.dd = dd; v.ds = ds;
    v.e_en = e_en; v.e_we = e_we; v.e_addr = e_addr; v.e_wd = e_wd;
    v.e_ir = e_ir; v.e_dr = e_dr; v.ck_rd = ck_rd; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic preload(input logic [10:0] a, input logic [31:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic idle_inputs();
    boot_valid = 0; boot_addr = 0; boot_wdata = 0; boot_wstrb = 0;
    i_valid = 0; i_addr = 0; d_valid = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
  endtask

  // Reference model state for the random phase
  logic [31:0] ref_mem [0:15];
  logic        m_last_d, m_ir, m_dr, m_dwr;
  logic [31:0] m_ird, m_drd;
  logic        i_busy, d_busy;
  localparam int G_NONE = 0, G_BOOT = 1, G_I = 2, G_D = 3;

  function automatic logic [31:0] rand_addr();
    return ($urandom_range(15) * 4) | ($urandom & 32'hFFFF_E000) | $urandom_range(3);
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic rand_cycle();
    int g;
    logic [31:0] ga;
    chk("rnd_i_ready", {31'b0, i_ready}, {31'b0, m_ir});
    chk("rnd_d_ready", {31'b0, d_ready}, {31'b0, m_dr});
    if (m_ir) chk("rnd_i_rdata", i_rdata, m_ird);
    if (m_dr && !m_dwr) chk("rnd_d_rdata", d_rdata, m_drd);
    if (m_ir) i_busy = 0;
    if (m_dr) d_busy = 0;
    if (!i_busy && $urandom_range(2) == 0) begin i_busy = 1; i_addr = rand_addr(); end
    if (!d_busy && $urandom_range(2) == 0) begin
      d_busy = 1; d_addr = rand_addr(); d_wdata = $urandom;
      d_wstrb = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
    end
    i_valid    = i_busy;
    d_valid    = d_busy;
    boot_valid = ($urandom_range(3) == 0);
    boot_addr  = rand_addr(); boot_wdata = $urandom; boot_wstrb = 4'($urandom);
    #1;
    g = G_NONE;
    if (boot_valid) g = G_BOOT;
    else if (i_valid && !m_ir && d_valid && !m_dr) g = m_last_d ? G_I : G_D;
    else if (i_valid && !m_ir) g = G_I;
    else if (d_valid && !m_dr) g = G_D;
    chk("rnd_sram_en", {31'b0, sram_en}, {31'b0, (g != G_NONE)});
    ga = (g == G_BOOT) ? boot_addr : (g == G_I) ? i_addr : d_addr;
    if (g != G_NONE) begin
      chk("rnd_sram_addr", {21'b0, sram_addr}, {21'b0, ga[12:2]});
      chk("rnd_sram_we", {28'b0, sram_we},
          {28'b0, (g == G_BOOT) ? boot_wstrb : (g == G_D) ? d_wstrb : 4'h0});
      chk("rnd_sram_wdata", sram_wdata,
          (g == G_BOOT) ? boot_wdata : (g == G_D) ? d_wdata : 32'h0);
    end
    m_ir = (g == G_I);
    m_dr = (g == G_D);
    if (g == G_I) begin m_ird = ref_mem[i_addr[5:2]]; m_last_d = 0; end
    if (g == G_D) begin
      m_dwr = (d_wstrb != 0); m_drd = ref_mem[d_addr[5:2]]; m_last_d = 1;
      ref_write(d_addr, d_wdata, d_wstrb);
    end
    if (g == G_BOOT) ref_write(boot_addr, boot_wdata, boot_wstrb);
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 16; k++) preload(11'(k), 32'hF0F0_0000 | k);
    preload(11'd0, 32'h1111_0000);
    preload(11'd2, 32'h2222_2222);
    preload(11'd3, 32'h3333_3333);
    preload(11'd4, 32'h4444_4444);
    preload(11'd5, 32'h1234_5678);
    // reset state, with a boot request present that must not reach the SRAM
    boot_valid = 1; boot_wstrb = 4'hF;
    #1;
    chk("rst_i_ready", {31'b0, i_ready}, 32'd0);
    chk("rst_d_ready", {31'b0, d_ready}, 32'd0);
    chk("rst_sram_en", {31'b0, sram_en}, 32'd0);
    chk("rst_sram_we", {28'b0, sram_we}, 32'd0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;

    //          bv ba       bd       bs    iv ia        dv da         dd            ds    en we    addr   wd            ir dr ck rd
    tbl.push_back(V(0, 0, 0, 0,         1, 32'h0,    1, 32'h8,    32'hCAFEBABE, 4'h3, 1, 4'h0, 11'd0, 32'h0,        0, 0, 0, 0));
    tbl.push_back(V(0, 0, 0, 0,         1, 32'h0,    1, 32'h8,    32'hCAFEBABE, 4'h3, 1, 4'h3, 11'd2, 32'hCAFEBABE, 1, 0, 1, 32'h1111_0000));
    tbl.push_back(V(0, 0, 0, 0,         0, 32'h0,    0, 32'h0,    32'h0,        4'h0, 0, 4'h0, 11'd0, 32'h0,        0, 1, 0, 0));
    tbl.push_back(V(0, 0, 0, 0,         1, 32'h10,   1, 32'h8,    32'h0,        4'h0, 1, 4'h0, 11'd4, 32'h0,        0, 0, 0, 0));
    tbl.push_back(V(0, 0, 0, 0,         0, 32'h0,    1, 32'h8,    32'h0,        4'h0, 1, 4'h0, 11'd2, 32'h0,        1, 0, 1, 32'h4444_4444));
    tbl.push_back(V(0, 0, 0, 0,         1, 32'h14,   0, 32'h0,    32'h0,        4'h0, 1, 4'h0, 11'd5, 32'h0,        0, 1, 1, 32'h2222_BABE));
    tbl.push_back(V(0, 0, 0, 0,         0, 32'h0,    0, 32'h0,    32'h0,        4'h0, 0, 4'h0, 11'd0, 32'h0,        1, 0, 1, 32'h1234_5678));
    tbl.push_back(V(0, 0, 0, 0,         1, 32'h0,    1, 32'hC,    32'h0,        4'h0, 1, 4'h0, 11'd3, 32'h0,        0, 0, 0, 0));
    tbl.push_back(V(0, 0, 0, 0,         1, 32'h0,    0, 32'h0,    32'h0,        4'h0, 1, 4'h0, 11'd0, 32'h0,        0, 1, 1, 32'h3333_3333));
    tbl.push_back(V(0, 0, 0, 0,         0, 32'h0,    0, 32'h0,    32'h0,        4'h0, 0, 4'h0, 11'd0, 32'h0,        1, 0, 1, 32'h1111_0000));
    for (int k = 0; k < 4; k++)
      tbl.push_back(V(1, 32'(4*k), 32'hA0 + k, 4'hF, 0, 0, 0, 0, 0, 0, 1, 4'hF, 11'(k), 32'hA0 + k, 0, 0, 0, 0));
    tbl.push_back(V(0, 0, 0, 0,         0, 32'h0,    0, 32'h0,    32'h0,        4'h0, 0, 4'h0, 11'd0, 32'h0,        0, 0, 0, 0));
    tbl.push_back(V(1, 32'h20, 32'hB0, 4'h0, 0, 32'h0, 1, 32'h4,  32'h0,        4'h0, 1, 4'h0, 11'd8, 32'hB0,       0, 0, 0, 0));
    tbl.push_back(V(1, 32'h24, 32'hB1, 4'hF, 0, 32'h0, 1, 32'h4,  32'h0,        4'h0, 1, 4'hF, 11'd9, 32'hB1,       0, 0, 0, 0));
    tbl.push_back(V(1, 32'h28, 32'hB2, 4'hF, 0, 32'h0, 1, 32'h4,  32'h0,        4'h0, 1, 4'hF, 11'd10, 32'hB2,      0, 0, 0, 0));
    tbl.push_back(V(0, 0, 0, 0,         0, 32'h0,    1, 32'h4,    32'h0,        4'h0, 1, 4'h0, 11'd1, 32'h0,        0, 0, 0, 0));
    tbl.push_back(V(0, 0, 0, 0,         0, 32'h0,    0, 32'h0,    32'h0,        4'h0, 0, 4'h0, 11'd0, 32'h0,        0, 1, 1, 32'hA1));
    tbl.push_back(V(0, 0, 0, 0,         0, 32'h0,    0, 32'h0,    32'h0,        4'h0, 0, 4'h0, 11'd0, 32'h0,        0, 0, 0, 0));
    tbl.push_back(V(0, 0, 0, 0,         0, 32'h0,    1, 32'h2004, 32'h55AA55AA, 4'hF, 1, 4'hF, 11'd1, 32'h55AA55AA, 0, 0, 0, 0));
    tbl.push_back(V(0, 0, 0, 0,         0, 32'h0,    0, 32'h0,    32'h0,        4'h0, 0, 4'h0, 11'd0, 32'h0,        0, 1, 0, 0));
    tbl.push_back(V(0, 0, 0, 0,         0, 32'h0,    1, 32'h4,    32'h0,        4'h0, 1, 4'h0, 11'd1, 32'h0,        0, 0, 0, 0));
    tbl.push_back(V(0, 0, 0, 0,         0, 32'h0,    0, 32'h0,    32'h0,        4'h0, 0, 4'h0, 11'd0, 32'h0,        0, 1, 1, 32'h55AA55AA));

    foreach (tbl[n]) begin
      boot_valid = tbl[n].bv; boot_addr = tbl[n].ba; boot_wdata = tbl[n].bd; boot_wstrb = tbl[n].bs;
      i_valid = tbl[n].iv; i_addr = tbl[n].ia;
      d_valid = tbl[n].dv; d_addr = tbl[n].da; d_wdata = tbl[n].dd; d_wstrb = tbl[n].ds;
      #1;
      chk($sformatf("vec%0d_sram_en", n), {31'b0, sram_en}, {31'b0, tbl[n].e_en});
      chk($sformatf("vec%0d_i_ready", n), {31'b0, i_ready}, {31'b0, tbl[n].e_ir});
      chk($sformatf("vec%0d_d_ready", n), {31'b0, d_ready}, {31'b0, tbl[n].e_dr});
      if (tbl[n].e_en) begin
        chk($sformatf("vec%0d_sram_we", n), {28'b0, sram_we}, {28'b0, tbl[n].e_we});
        chk($sformatf("vec%0d_sram_addr", n), {21'b0, sram_addr}, {21'b0, tbl[n].e_addr});
        chk($sformatf("vec%0d_sram_wdata", n), sram_wdata, tbl[n].e_wd);
      end
      if (tbl[n].ck_rd && tbl[n].e_ir) chk($sformatf("vec%0d_i_rdata", n), i_rdata, tbl[n].e_rd);
      if (tbl[n].ck_rd && tbl[n].e_dr) chk($sformatf("vec%0d_d_rdata", n), d_rdata, tbl[n].e_rd);
      @(negedge clk);
    end
    idle_inputs();

    // Reset asserted right after an instruction grant: the ready is dropped,
    // then the still-held request is re-granted and completes once.
    i_valid = 1; i_addr = 32'h14;
    #1;
    chk("rmt_grant_en", {31'b0, sram_en}, 32'd1);
    chk("rmt_grant_addr", {21'b0, sram_addr}, 32'd5);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rmt_i_ready_dropped", {31'b0, i_ready}, 32'd0);
    chk("rmt_en_in_reset", {31'b0, sram_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rmt_regrant_en", {31'b0, sram_en}, 32'd1);
    chk("rmt_regrant_addr", {21'b0, sram_addr}, 32'd5);
    @(negedge clk);
    chk("rmt_i_ready", {31'b0, i_ready}, 32'd1);
    chk("rmt_i_rdata", i_rdata, 32'h1234_5678);
    i_valid = 0;
    @(negedge clk);
    chk("rmt_i_ready_once", {31'b0, i_ready}, 32'd0);

    // Random traffic against the transaction-level model
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) ref_mem[k] = mem[k];
    m_last_d = 1; m_ir = 0; m_dr = 0; m_dwr = 0; m_ird = 0; m_drd = 0;
    i_busy = 0; d_busy = 0;
    for (int c = 0; c < 800; c++) rand_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/int_mem_sram_arb.md
Name: int_mem_sram_arb

Overview:
- Single-port SRAM access arbiter in the internal-memory subsystem, directly downstream of the boot controller's SRAM master write port.
- Merges three masters onto one synchronous single-port SRAM:
  - boot-loader write stream (highest priority, never stalled);
  - CPU instruction bus (read-only);
  - CPU data bus (read/write).
- Generates the iob-native ready/rdata responses for the two CPU buses.

Parameters:
- DATA_W, 32, data width of all buses and SRAM.
- ADDR_W, 32, byte-address width of master buses.
- SRAM_ADDR_W, 13, SRAM byte-address width; SRAM word address is SRAM_ADDR_W-2 bits.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- boot_valid  in  1  boot-loader write request; no handshake, consumed the same cycle.
- boot_addr  in  ADDR_W  boot write byte address.
- boot_wdata  in  DATA_W  boot write data.
- boot_wstrb  in  DATA_W/8  boot write byte strobes.
- i_valid  in  1  instruction read request.
- i_addr  in  ADDR_W  instruction byte address.
- i_rdata  out  DATA_W  instruction read data.
- i_ready  out  1  instruction transfer complete.
- d_valid  in  1  data request.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  data write data.
- d_wstrb  in  DATA_W/8  data strobes; all-zero means read.
- d_rdata  out  DATA_W  data read data.
- d_ready  out  1  data transfer complete.
- sram_en  out  1  SRAM access enable.
- sram_we  out  DATA_W/8  SRAM byte write enables.
- sram_addr  out  SRAM_ADDR_W-2  SRAM word address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data; valid the cycle after sram_en.

Behaviour:
- **Protocol.** Masters hold valid/addr/wdata/wstrb stable until they see ready. ready is a one-cycle pulse.
- **Eligibility.** In each cycle, i is eligible if i_valid & !i_ready; d is eligible if d_valid & !d_ready. A master in its ready cycle is never re-granted.
- **Grant priority (combinational, cycle N):**
  1. boot_valid → boot granted; i and d not granted.
  2. Else if exactly one of i/d is eligible → that master is granted.
  3. Else if both are eligible → round-robin: grant the one not recorded in last_grant.
  4. Else → no grant; sram_en=0.
- **last_grant register.** 1 bit, 0=i, 1=d, reset value 1 (so i wins the first tie). Updated only on i/d grants; boot grants leave it unchanged.
- **SRAM drive in cycle N:**
  - sram_en=1 for any grant.
  - sram_addr = granted addr[SRAM_ADDR_W-1:2]; upper address bits and addr[1:0] are ignored.
  - sram_wdata = granted wdata; i grant drives 0.
  - sram_we: boot → boot_wstrb; d → d_wstrb; i → 0.
- **Response.** i_ready and d_ready are registered. The granted CPU master sees ready=1 in cycle N+1 (latency 1), for reads and writes alike.
- **Read data.** i_rdata = d_rdata = sram_rdata (combinational), defined only while the respective ready is high. d write completions return don't-care data.
- **Throughput.**
  - Per master: max 1 transfer per 2 cycles.
  - Aggregate: 1 SRAM access per cycle when i and d alternate.
- **Boot stream.**
  - No ready is produced for boot accesses.
  - boot_wstrb=0 still asserts sram_en, with no write.
  - A CPU request pending during boot_valid waits; its valid stays high, with no loss or duplication.
- **Reset.**
  - While rst is high: i_ready=0, d_ready=0, last_grant=1, and sram_en/sram_we are forced to 0.
  - Reset asserted mid-transfer discards the pending ready; after reset the master's held valid is re-arbitrated normally.
- **Address wrap.** Addresses beyond the SRAM size alias by truncation; no error is flagged.

Test Plan:
- **Boot burst:** boot_valid for 4 cycles, addr 0x0,0x4,0x8,0xC, wstrb 0xF, data 0xA0..0xA3 → sram_en=1, sram_we=0xF, sram_addr 0..3 on those same cycles; i_ready/d_ready stay 0.
- **Instruction read:** preload word 5 = 0x12345678; i_valid, i_addr=0x14 → sram_en with addr 5 in cycle N; i_ready=1 and i_rdata=0x12345678 in N+1; no regrant in N+1.
- **Simultaneous i/d after reset:** i reads 0x0, d writes 0x8 with d_wstrb=0x3 → cycle N grants i; cycle N+1 grants d with sram_we=0x3 while i_ready=1; d_ready=1 at N+2; further ties alternate i,d,i.
- **Boot collision:** d_valid (read 0x4) held while boot_valid is high for 3 cycles → d is not granted during those cycles; granted the first cycle boot_valid=0; d_ready exactly once, one cycle later.
- **Address aliasing:** d write, addr = 0x4 + 2^SRAM_ADDR_W → sram_addr=1.
- **Reset mid-transfer:** rst asserted in the cycle after an i grant → i_ready stays 0; after release, with i_valid held, i is regranted and completes once with correct data.
